// File: rtl/fb_draw_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fb_draw_ctrl_pkg : opcodes, state encoding and geometry for fb_draw_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
package fb_draw_ctrl_pkg;

  localparam int FB_X_W    = 8;
  localparam int FB_Y_W    = 7;
  localparam int FB_ADDR_W = FB_X_W + FB_Y_W;

  localparam logic [2:0] OP_SET_PIXEL = 3'd1;
  localparam logic [2:0] OP_GET_PIXEL = 3'd2;
  localparam logic [2:0] OP_FILL      = 3'd3;
  localparam logic [2:0] OP_CHECKER   = 3'd4;
  localparam logic [2:0] OP_INVERT    = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WR1     = 4'd1,
    ST_RD_ADDR = 4'd2,
    ST_RD_WAIT = 4'd3,
    ST_RD_DONE = 4'd4,
    ST_SWEEP   = 4'd5,
    ST_INV_RD  = 4'd6,
    ST_INV_WR  = 4'd7,
    ST_FIN     = 4'd8
  } fb_state_e;

endpackage
`default_nettype wire

// File: rtl/fb_sweep_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fb_sweep_counter : full-screen address counter with last flag and X/Y split
// Rev 1.0
// ----------------------------------------------------------------------------
module fb_sweep_counter
  import fb_draw_ctrl_pkg::*;
#(
  parameter int X_W = FB_X_W,
  parameter int Y_W = FB_Y_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  output logic           last,
  output logic [X_W-1:0] nxt_x,
  output logic [Y_W-1:0] nxt_y
);

  localparam int ADDR_W = X_W + Y_W;

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The split exposes the value being loaded so the caller can register the
  // matching address in the same cycle the counter advances.
  assign last  = &cnt_q;
  assign nxt_x = cnt_d[X_W-1:0];
  assign nxt_y = cnt_d[ADDR_W-1:X_W];

endmodule
`default_nettype wire

// File: rtl/fb_draw_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fb_draw_ctrl : frame-buffer Port A drawing command sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
module fb_draw_ctrl
  import fb_draw_ctrl_pkg::*;
#(
  parameter int X_W = FB_X_W,
  parameter int Y_W = FB_Y_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [X_W-1:0]     cmd_x,
  input  logic [Y_W-1:0]     cmd_y,
  input  logic               cmd_color,
  input  logic [2:0]         cmd_grid,
  input  logic               cmd_abort,
  output logic [X_W+Y_W-1:0] fb_addr,
  output logic               fb_we,
  output logic               fb_wdata,
  input  logic               fb_rdata,
  output logic               rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int ADDR_W = X_W + Y_W;

  fb_state_e         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              color_q, color_d;
  logic [2:0]        grid_q, grid_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              fb_we_q, fb_we_d;
  logic              fb_wdata_q, fb_wdata_d;
  logic              rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q;

  logic              cnt_clr, cnt_en, cnt_last;
  logic [X_W-1:0]    nxt_x;
  logic [Y_W-1:0]    nxt_y;

  fb_sweep_counter #(.X_W(X_W), .Y_W(Y_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (cnt_last),
    .nxt_x (nxt_x),
    .nxt_y (nxt_y)
  );

  // Rows beyond the Y range read as 0, so g=7 degenerates to X[7].
  function automatic logic checker_pix(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                       input logic [2:0] g);
    logic [X_W-1:0] y_ext;
    y_ext = X_W'(y);
    return x[g] ^ y_ext[g];
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    color_d    = color_q;
    grid_d     = grid_q;
    fb_addr_d  = fb_addr_q;
    fb_we_d    = 1'b0;
    fb_wdata_d = fb_wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          color_d = cmd_color;
          grid_d  = cmd_grid;
          cnt_clr = 1'b1;
          case (cmd_op)
            OP_SET_PIXEL: begin
              state_d    = ST_WR1;
              fb_addr_d  = {cmd_y, cmd_x};
              fb_we_d    = 1'b1;
              fb_wdata_d = cmd_color;
              done_d     = 1'b1;
            end
            OP_GET_PIXEL: begin
              state_d   = ST_RD_ADDR;
              fb_addr_d = {cmd_y, cmd_x};
            end
            OP_FILL, OP_CHECKER: begin
              state_d    = ST_SWEEP;
              fb_addr_d  = {nxt_y, nxt_x};
              fb_we_d    = 1'b1;
              fb_wdata_d = (cmd_op == OP_FILL) ? cmd_color : checker_pix(nxt_x, nxt_y, cmd_grid);
            end
            OP_INVERT: begin
              state_d   = ST_INV_RD;
              fb_addr_d = {nxt_y, nxt_x};
            end
            default: begin
              state_d = ST_FIN;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_WR1:     state_d = ST_IDLE;
      ST_RD_ADDR: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        state_d    = ST_RD_DONE;
        rd_data_d  = fb_rdata;
        rd_valid_d = 1'b1;
        done_d     = 1'b1;
      end
      ST_RD_DONE: state_d = ST_IDLE;
      ST_SWEEP: begin
        if (cmd_abort || cnt_last) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          cnt_en     = 1'b1;
          fb_addr_d  = {nxt_y, nxt_x};
          fb_we_d    = 1'b1;
          fb_wdata_d = (op_q == OP_FILL) ? color_q : checker_pix(nxt_x, nxt_y, grid_q);
        end
      end
      ST_INV_RD: begin
        if (cmd_abort) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = ST_INV_WR;
          fb_we_d = 1'b1;
        end
      end
      ST_INV_WR: begin
        if (cmd_abort || cnt_last) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          state_d   = ST_INV_RD;
          cnt_en    = 1'b1;
          fb_addr_d = {nxt_y, nxt_x};
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      color_q     <= 1'b0;
      grid_q      <= 3'd0;
      fb_addr_q   <= '0;
      fb_we_q     <= 1'b0;
      fb_wdata_q  <= 1'b0;
      rd_data_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      color_q     <= color_d;
      grid_q      <= grid_d;
      fb_addr_q   <= fb_addr_d;
      fb_we_q     <= fb_we_d;
      fb_wdata_q  <= fb_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= ~cmd_ready_d;
    end
  end

  // The read data for an invert only arrives in the write cycle itself, so
  // that one case bypasses the write-data register.
  assign fb_wdata  = (state_q == ST_INV_WR) ? ~fb_rdata : fb_wdata_q;
  assign fb_addr   = fb_addr_q;
  assign fb_we     = fb_we_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
